// File: rtl/unsharp_mask_host.sv
// Host wrapper for an ap_ctrl_hs unsharp-mask accelerator: loads coefficients and the image
// from a stream, serves the accelerator's reads, captures its result writes and streams them out.
module unsharp_mask_host #(
  parameter int IMG_WORDS    = 1024,
  parameter int KERNEL_WORDS = 8
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        ap_start,
  input  logic        ap_done,
  input  logic        ap_idle,
  input  logic        ap_ready,
  input  logic        img_ce0,
  input  logic [9:0]  img_address0,
  output logic [31:0] img_q0,
  input  logic        mask_img_ce0,
  input  logic        mask_img_we0,
  input  logic [9:0]  mask_img_address0,
  input  logic [31:0] mask_img_d0,
  input  logic        kernelDataX_ce0,
  input  logic [2:0]  kernelDataX_address0,
  output logic [31:0] kernelDataX_q0,
  input  logic        kernelDataY_ce0,
  input  logic [2:0]  kernelDataY_address0,
  output logic [31:0] kernelDataY_q0,
  output logic        err
);

  // state | meaning
  // LOAD  | accepting X coefficients, Y coefficients, then image words
  // START | ap_start held high until the accelerator reports ap_ready
  // RUN   | accelerator busy, waiting for ap_done
  // DRAIN | streaming result RAM out through a read prefetch and one-entry skid
  typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

  localparam logic [10:0] LD_Y0   = 11'(KERNEL_WORDS);
  localparam logic [10:0] LD_IMG0 = 11'(2 * KERNEL_WORDS);
  localparam logic [10:0] LD_LAST = 11'(2 * KERNEL_WORDS + IMG_WORDS - 1);
  localparam logic [10:0] IMG_END = 11'(IMG_WORDS);
  localparam logic [10:0] IMG_FIN = 11'(IMG_WORDS - 1);
  localparam logic [3:0]  KER_END = 4'(KERNEL_WORDS);

  logic [31:0] x_ram    [0:7];
  logic [31:0] y_ram    [0:7];
  logic [31:0] img_ram  [0:1023];
  logic [31:0] mask_ram [0:1023];

  state_t      state_q, state_d;
  logic [10:0] load_cnt_q, load_cnt_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_last_q, rd_last_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic        skid_last_q, skid_last_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        load_ready_q, load_ready_d;
  logic        ap_start_q, ap_start_d;
  logic        err_q, err_d;
  logic [31:0] img_q0_q, img_q0_d;
  logic [31:0] kx_q0_q, kx_q0_d;
  logic [31:0] ky_q0_q, ky_q0_d;

  logic        load_fire, mask_wr, mask_wr_ok;
  logic        img_rd_ok, kx_rd_ok, ky_rd_ok;
  logic        pop, issue;
  logic [1:0]  held;
  logic [2:0]  ky_idx;
  logic [9:0]  img_idx;
  logic [31:0] rd_word;

  // ap_idle carries nothing this host needs; ap_ready/ap_done drive the sequencing.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  always_comb begin
    load_fire  = load_valid && load_ready_q;
    mask_wr    = mask_img_ce0 && mask_img_we0;
    mask_wr_ok = {1'b0, mask_img_address0} < IMG_END;
    img_rd_ok  = {1'b0, img_address0} < IMG_END;
    kx_rd_ok   = {1'b0, kernelDataX_address0} < KER_END;
    ky_rd_ok   = {1'b0, kernelDataY_address0} < KER_END;
    ky_idx     = 3'(load_cnt_q - LD_Y0);
    img_idx    = 10'(load_cnt_q - LD_IMG0);
    // Forward a same-cycle result write so the first prefetch never sees stale data.
    rd_word    = (mask_wr && mask_wr_ok && (mask_img_address0 == rd_addr_q[9:0]))
                 ? mask_img_d0 : mask_ram[rd_addr_q[9:0]];

    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_addr_d  = rd_addr_q;
    pop        = out_valid_q && out_ready;

    case (state_q)
      LOAD: begin
        if (load_fire) begin
          if (load_cnt_q == LD_LAST) begin
            state_d    = START;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 11'd1;
          end
        end
      end
      START: begin
        if (ap_ready) state_d = ap_done ? DRAIN : RUN;
      end
      RUN: begin
        if (ap_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last_q) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase

    // Words that will sit in out/skid after this edge; a new read needs room for one more.
    held  = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_valid_q) - 2'(pop);
    issue = (state_d == DRAIN) && (rd_addr_q < IMG_END) && (held <= 2'd1);

    rd_valid_d = issue;
    rd_data_d  = issue ? rd_word : rd_data_q;
    rd_last_d  = issue && (rd_addr_q == IMG_FIN);
    if (issue) rd_addr_d = rd_addr_q + 11'd1;
    if (state_q == DRAIN && state_d == LOAD) rd_addr_d = '0;

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = rd_valid_q;
        skid_data_d  = rd_data_q;
        skid_last_d  = rd_last_q;
      end else if (rd_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = rd_data_q;
        out_last_d   = rd_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
      end
    end else if (rd_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rd_data_q;
      skid_last_d  = rd_last_q;
    end

    img_q0_d = img_q0_q;
    if (img_ce0) img_q0_d = img_rd_ok ? img_ram[img_address0] : '0;
    kx_q0_d = kx_q0_q;
    if (kernelDataX_ce0) kx_q0_d = kx_rd_ok ? x_ram[kernelDataX_address0] : '0;
    ky_q0_d = ky_q0_q;
    if (kernelDataY_ce0) ky_q0_d = ky_rd_ok ? y_ram[kernelDataY_address0] : '0;

    err_d = err_q;
    if (ap_done && (state_q == LOAD || state_q == DRAIN)) err_d = 1'b1;
    if (img_ce0 && !img_rd_ok)         err_d = 1'b1;
    if (kernelDataX_ce0 && !kx_rd_ok)  err_d = 1'b1;
    if (kernelDataY_ce0 && !ky_rd_ok)  err_d = 1'b1;
    if (mask_wr && !mask_wr_ok)        err_d = 1'b1;

    load_ready_d = (state_d == LOAD);
    ap_start_d   = (state_d == START);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= LOAD;
      load_cnt_q   <= '0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      load_ready_q <= 1'b0;
      ap_start_q   <= 1'b0;
      err_q        <= 1'b0;
      img_q0_q     <= '0;
      kx_q0_q      <= '0;
      ky_q0_q      <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      rd_addr_q    <= rd_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      load_ready_q <= load_ready_d;
      ap_start_q   <= ap_start_d;
      err_q        <= err_d;
      img_q0_q     <= img_q0_d;
      kx_q0_q      <= kx_q0_d;
      ky_q0_q      <= ky_q0_d;
    end
  end

  // Storage arrays are never reset.
  always_ff @(posedge ap_clk) begin
    if (load_fire) begin
      if (load_cnt_q < LD_Y0)        x_ram[load_cnt_q[2:0]] <= load_data;
      else if (load_cnt_q < LD_IMG0) y_ram[ky_idx]          <= load_data;
      else                           img_ram[img_idx]       <= load_data;
    end
    if (mask_wr && mask_wr_ok) mask_ram[mask_img_address0] <= mask_img_d0;
  end

  assign load_ready     = load_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign ap_start       = ap_start_q;
  assign img_q0         = img_q0_q;
  assign kernelDataX_q0 = kx_q0_q;
  assign kernelDataY_q0 = ky_q0_q;
  assign err            = err_q;

endmodule

// File: tb/tb_unsharp_mask_host.sv
// Directed bench for unsharp_mask_host: load ramp, handshake, backpressured drain, reset mid-run,
// out-of-range accesses on a reduced build, and the ready/done shortcut into DRAIN.
module tb_unsharp_mask_host;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        ap_rst = 1'b1;
  logic        load_valid = 1'b0, load_ready;
  logic [31:0] load_data = '0;
  logic        out_valid, out_ready = 1'b0, out_last;
  logic [31:0] out_data;
  logic        ap_start, ap_done = 1'b0, ap_ready = 1'b0;
  logic        img_ce0 = 1'b0;
  logic [9:0]  img_address0 = '0;
  logic [31:0] img_q0;
  logic        mask_img_ce0 = 1'b0, mask_img_we0 = 1'b0;
  logic [9:0]  mask_img_address0 = '0;
  logic [31:0] mask_img_d0 = '0;
  logic        kx_ce0 = 1'b0, ky_ce0 = 1'b0;
  logic [2:0]  kx_addr = '0, ky_addr = '0;
  logic [31:0] kx_q0, ky_q0;
  logic        err;

  logic        s_img_ce0 = 1'b0, s_kx_ce0 = 1'b0, s_wr_ce0 = 1'b0;
  logic [9:0]  s_img_addr = '0, s_wr_addr = '0;
  logic [2:0]  s_kx_addr = '0;
  logic        s_load_ready, s_out_valid, s_out_last, s_ap_start, s_err;
  logic [31:0] s_out_data, s_img_q0, s_kx_q0, s_ky_q0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  localparam logic [31:0] PAT2 = 32'hA5A5_0000;

  unsharp_mask_host #(.IMG_WORDS(1024), .KERNEL_WORDS(8)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(1'b0), .ap_ready(ap_ready),
    .img_ce0(img_ce0), .img_address0(img_address0), .img_q0(img_q0),
    .mask_img_ce0(mask_img_ce0), .mask_img_we0(mask_img_we0),
    .mask_img_address0(mask_img_address0), .mask_img_d0(mask_img_d0),
    .kernelDataX_ce0(kx_ce0), .kernelDataX_address0(kx_addr), .kernelDataX_q0(kx_q0),
    .kernelDataY_ce0(ky_ce0), .kernelDataY_address0(ky_addr), .kernelDataY_q0(ky_q0),
    .err(err)
  );

  unsharp_mask_host #(.IMG_WORDS(1000), .KERNEL_WORDS(4)) u_small (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .load_valid(1'b0), .load_ready(s_load_ready), .load_data(32'd0),
    .out_valid(s_out_valid), .out_ready(1'b0), .out_data(s_out_data), .out_last(s_out_last),
    .ap_start(s_ap_start), .ap_done(1'b0), .ap_idle(1'b0), .ap_ready(1'b0),
    .img_ce0(s_img_ce0), .img_address0(s_img_addr), .img_q0(s_img_q0),
    .mask_img_ce0(s_wr_ce0), .mask_img_we0(s_wr_ce0),
    .mask_img_address0(s_wr_addr), .mask_img_d0(32'h1234_5678),
    .kernelDataX_ce0(s_kx_ce0), .kernelDataX_address0(s_kx_addr), .kernelDataX_q0(s_kx_q0),
    .kernelDataY_ce0(1'b0), .kernelDataY_address0(3'd0), .kernelDataY_q0(s_ky_q0),
    .err(s_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge ap_clk); ap_rst = 1'b1;
    @(negedge ap_clk); ap_rst = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic load_stream(input logic [31:0] pat);
    int k = 0;
    int guard = 0;
    while (k < 1040 && guard < 4000) begin
      @(negedge ap_clk); guard++;
      if (load_ready && ($urandom_range(0, 4) != 0)) begin
        load_valid = 1'b1; load_data = 32'(k) ^ pat; k++;
      end else begin
        load_valid = 1'b0;
      end
    end
    @(negedge ap_clk); load_valid = 1'b0;
    check("load_count", 32'(k), 32'd1040);
    check("load_ready_after_last", 32'(load_ready), 32'd0);
    check("ap_start_after_load", 32'(ap_start), 32'd1);
  endtask

  task automatic write_mask(input int mult, input int add);
    for (int i = 0; i < 1024; i++) begin
      @(negedge ap_clk);
      mask_img_ce0 = 1'b1; mask_img_we0 = 1'b1;
      mask_img_address0 = 10'(i); mask_img_d0 = 32'(i * mult + add);
      exp_q.push_back(32'(i * mult + add));
    end
    @(negedge ap_clk);
    mask_img_we0 = 1'b0; mask_img_address0 = '0; mask_img_d0 = 32'hFFFF_FFFF;
    @(negedge ap_clk);
    mask_img_ce0 = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    int guard = 0;
    bit stalled = 1'b0;
    bit started = 1'b0;
    logic [31:0] held_data = '0;
    logic [31:0] e;
    while (n < 1024 && guard < 6000) begin
      @(negedge ap_clk); guard++;
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, held_data);
        stalled = 1'b0;
      end
      out_ready = toggle ? guard[0] : 1'b1;
      if (!toggle && started) check("no_bubble", 32'(out_valid), 32'd1);
      if (out_valid) begin
        started = 1'b1;
        if (out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
          check("drain_data", out_data, e);
          check("drain_last", 32'(out_last), 32'(n == 1023));
          n++;
        end else begin
          stalled = 1'b1; held_data = out_data;
        end
      end
    end
    @(negedge ap_clk); out_ready = 1'b0;
    check("drain_count", 32'(n), 32'd1024);
    check("valid_after_last", 32'(out_valid), 32'd0);
    check("load_ready_after_drain", 32'(load_ready), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int hi;
    bit seen;

    repeat (3) @(negedge ap_clk);
    check("rst_ap_start", 32'(ap_start), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_img_q0", img_q0, 32'd0);
    check("rst_kx_q0", kx_q0, 32'd0);
    check("rst_ky_q0", ky_q0, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("load_ready_after_rst", 32'(load_ready), 32'd1);
    check("s_load_ready", 32'(s_load_ready), 32'd1);
    check("s_idle_outputs", {s_ap_start, s_out_valid, s_out_last}, 32'd0);
    check("s_out_data", s_out_data, 32'd0);
    check("s_ky_q0", s_ky_q0, 32'd0);
    check("s_err_clear", 32'(s_err), 32'd0);

    // Reduced build: last legal addresses are fine, the next ones are not.
    s_img_ce0 = 1'b1; s_img_addr = 10'd999; s_kx_ce0 = 1'b1; s_kx_addr = 3'd3;
    @(negedge ap_clk); s_img_ce0 = 1'b0; s_kx_ce0 = 1'b0;
    check("s_inrange_no_err", 32'(s_err), 32'd0);
    s_img_ce0 = 1'b1; s_img_addr = 10'd1000;
    @(negedge ap_clk); s_img_ce0 = 1'b0;
    check("s_oob_img_q0", s_img_q0, 32'd0);
    check("s_oob_img_err", 32'(s_err), 32'd1);
    pulse_reset();
    check("s_err_after_rst", 32'(s_err), 32'd0);
    s_kx_ce0 = 1'b1; s_kx_addr = 3'd4;
    @(negedge ap_clk); s_kx_ce0 = 1'b0;
    check("s_oob_kx_q0", s_kx_q0, 32'd0);
    check("s_oob_kx_err", 32'(s_err), 32'd1);
    pulse_reset();
    s_wr_ce0 = 1'b1; s_wr_addr = 10'd1000;
    @(negedge ap_clk); s_wr_ce0 = 1'b0;
    check("s_oob_wr_err", 32'(s_err), 32'd1);
    pulse_reset();
    check("main_err_clean", 32'(err), 32'd0);

    // Run 1: ramp load, slow ap_ready, reads in RUN, backpressured drain.
    load_stream(32'd0);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (ap_start) hi++;
      @(negedge ap_clk);
    end
    if (ap_start) hi++;
    ap_ready = 1'b1;
    @(negedge ap_clk); ap_ready = 1'b0;
    check("ap_start_drop", 32'(ap_start), 32'd0);
    check("ap_start_cycles", 32'(hi), 32'd5);

    img_ce0 = 1'b1; img_address0 = 10'd5;
    kx_ce0 = 1'b1; kx_addr = 3'd3; ky_ce0 = 1'b1; ky_addr = 3'd3;
    @(negedge ap_clk);
    img_ce0 = 1'b0; kx_ce0 = 1'b0; ky_ce0 = 1'b0; img_address0 = 10'd6;
    check("img_read5", img_q0, 32'd21);
    check("kx_read3", kx_q0, 32'd3);
    check("ky_read3", ky_q0, 32'd11);
    @(negedge ap_clk);
    check("img_hold", img_q0, 32'd21);
    img_ce0 = 1'b1; img_address0 = 10'd1023;
    @(negedge ap_clk); img_ce0 = 1'b0;
    check("img_read1023", img_q0, 32'd1039);

    write_mask(3, 0);
    repeat (20) @(negedge ap_clk);
    check("ap_start_in_run", 32'(ap_start), 32'd0);
    ap_done = 1'b1;
    @(negedge ap_clk); ap_done = 1'b0;
    check("err_after_run_done", 32'(err), 32'd0);
    drain(1'b1);

    // Run 2: abandoned by reset in RUN.
    load_stream(PAT2);
    ap_ready = 1'b1;
    @(negedge ap_clk); ap_ready = 1'b0;
    check("ap_start_drop2", 32'(ap_start), 32'd0);
    @(negedge ap_clk); ap_rst = 1'b1;
    @(negedge ap_clk);
    check("mid_rst_outputs",
          {25'd0, ap_start, load_ready, out_valid, out_last, err, 2'b00}, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_img_q0", img_q0, 32'd0);
    check("mid_rst_kx_q0", kx_q0, 32'd0);
    check("mid_rst_ky_q0", ky_q0, 32'd0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("load_ready_after_mid_rst", 32'(load_ready), 32'd1);

    // Run 3: full reload, ready and done together in START, drain with out_ready held high.
    write_mask(5, 7);
    load_stream(PAT2);
    img_ce0 = 1'b1; img_address0 = 10'd5;
    kx_ce0 = 1'b1; kx_addr = 3'd3; ky_ce0 = 1'b1; ky_addr = 3'd3;
    @(negedge ap_clk);
    img_ce0 = 1'b0; kx_ce0 = 1'b0; ky_ce0 = 1'b0;
    check("reload_img5", img_q0, 32'd21 ^ PAT2);
    check("reload_kx3", kx_q0, 32'd3 ^ PAT2);
    check("reload_ky3", ky_q0, 32'd11 ^ PAT2);
    check("ap_start_held", 32'(ap_start), 32'd1);
    ap_ready = 1'b1; ap_done = 1'b1;
    @(negedge ap_clk); ap_ready = 1'b0; ap_done = 1'b0;
    check("ap_start_after_ready_done", 32'(ap_start), 32'd0);
    seen = out_valid;
    if (!seen) begin
      @(negedge ap_clk);
      seen = out_valid;
    end
    check("valid_within_2", 32'(seen), 32'd1);
    check("err_before_load_done", 32'(err), 32'd0);
    drain(1'b0);

    // Spurious ap_done while loading.
    ap_done = 1'b1;
    @(negedge ap_clk); ap_done = 1'b0;
    check("load_done_err", 32'(err), 32'd1);
    check("load_done_ready", 32'(load_ready), 32'd1);
    check("load_done_start", 32'(ap_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
